// File: rtl/mem_responder_if.sv
// Word-wide memory bus between an initiator (CPU) and a memory-side responder.
// The initiator holds req until it sees a one-cycle ready pulse.
interface mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_responder.sv
// Memory-side bus endpoint: word RAM behind a fixed number of wait states,
// answering each request with a registered one-cycle ready/err/rdata response.
module mem_responder #(
  parameter int    DEPTH       = 64,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input logic clk,
  input logic reset_n,
  mem_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic          accept, access;
  logic          cur_we, cur_err;
  logic [31:0]   cur_addr, cur_wdata;
  logic [AW-1:0] cur_idx;
  logic [31:0]   mem [DEPTH];

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.req) begin
        accept  = 1'b1;
        state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      end
      WAIT:    if (cnt_q <= 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM access fires on the edge entering RESP; with zero wait states that
  // is the accept edge itself, so the live bus fields are used instead of the latches.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = bus.we;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
    end
    cur_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
    cur_idx = cur_addr[AW+1:2];
    access  = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus.rdata <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        cnt_q   <= 4'(WAIT_CYCLES);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      bus.ready <= access;
      bus.err   <= access && cur_err;
      bus.busy  <= (state_d != IDLE);
      if (access) begin
        if (cur_err)      bus.rdata <= '0;
        else if (!cur_we) bus.rdata <= mem[cur_idx];
      end
    end
  end

  // NOTE: the RAM array is deliberately not reset; only the write enable is
  // gated by reset so an in-flight write is dropped while contents survive.
  always_ff @(posedge clk) begin
    if (reset_n && access && cur_we && !cur_err) mem[cur_idx] <= cur_wdata;
  end

endmodule
